// File: rtl/sale_terminal_pkg.sv
// Shared types and constants for the sale terminal keypad and item-lookup stages.
package sale_terminal_pkg;

  localparam int unsigned BCD_W  = 4;
  localparam int unsigned CODE_W = 16;
  localparam int unsigned QTY_W  = 3;
  localparam int unsigned KEY_N  = 4;

  // Key indices, named after their function in digit mode / command mode.
  localparam int unsigned KEY_D1_COMMIT = 3;
  localparam int unsigned KEY_D2_BACK   = 2;
  localparam int unsigned KEY_D3_CLEAR  = 1;
  localparam int unsigned KEY_D4_RSVD   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_QTY   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_DIGIT,
    EV_BACK,
    EV_CLEAR,
    EV_COMMIT
  } ev_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [QTY_W-1:0]  qty;
  } item_t;

  // KEY[3] enters 1 ... KEY[0] enters 4.
  function automatic logic [QTY_W-1:0] digit_of(input logic [1:0] idx);
    return 3'd4 - {1'b0, idx};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low push button: 2-flop synchronizer, stability counter and
// a registered one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has been stable long enough; any bounce restarts the count.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Armed once the button is seen released, so a key held through reset gives no press.
    armed_d = armed_q | (sync2_q & level_q);
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = armed_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronizer resets to "pressed" so a held key cannot look released right after reset.
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values.
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/barcode_entry.sv
// Keypad front end: decodes debounced key presses into entry events and
// assembles a 4-digit BCD code plus quantity for the item-lookup stage.
module barcode_entry
  import sale_terminal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DIGITS          = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  input  logic        SW_SHIFT,
  output logic [15:0] code_o,
  output logic [2:0]  count_o,
  output logic [2:0]  qty_o,
  output logic        item_valid_o,
  input  logic        item_ready_i,
  output logic        err_o,
  output logic [1:0]  state_o
);

  logic [KEY_N-1:0]  press;
  logic              shift1_q, shift2_q;
  logic              ev_any;
  logic [1:0]        ev_idx;
  ev_e               ev;
  logic [QTY_W-1:0]  ev_digit;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [2:0]        count_q, count_d;
  logic [QTY_W-1:0]  qty_q, qty_d;
  logic              err_q, err_d;

  for (genvar i = 0; i < KEY_N; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (CLOCK_50),
      .rst_n   (RESET_N),
      .key_n_i (KEY[i]),
      .press_o (press[i])
    );
  end

  // Pick the highest-index press and decode it with the synchronized shift switch.
  always_comb begin
    ev_any = 1'b0;
    ev_idx = 2'd0;
    for (int i = 0; i < KEY_N; i++) begin
      if (press[i]) begin
        ev_any = 1'b1;
        ev_idx = 2'(i);
      end
    end
    ev       = EV_NONE;
    ev_digit = digit_of(ev_idx);
    if (ev_any) begin
      if (!shift2_q) begin
        ev = EV_DIGIT;
      end else begin
        case (int'(ev_idx))
          KEY_D1_COMMIT: ev = EV_COMMIT;
          KEY_D2_BACK:   ev = EV_BACK;
          KEY_D3_CLEAR:  ev = EV_CLEAR;
          default:       ev = EV_NONE;
        endcase
      end
    end
  end

  // Entry FSM: next state, code/count/qty update and error pulse.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = count_q;
    qty_d   = qty_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        case (ev)
          EV_DIGIT: begin
            if (count_q == 3'(DIGITS)) begin
              err_d = 1'b1;
            end else begin
              code_d  = {code_q[CODE_W-BCD_W-1:0], BCD_W'(ev_digit)};
              count_d = count_q + 3'd1;
              state_d = ST_ENTRY;
            end
          end
          EV_BACK: begin
            if (state_q == ST_ENTRY) begin
              code_d  = {BCD_W'(0), code_q[CODE_W-1:BCD_W]};
              count_d = count_q - 3'd1;
              if (count_q == 3'd1) state_d = ST_IDLE;
            end
          end
          EV_CLEAR: begin
            code_d  = '0;
            count_d = '0;
            qty_d   = '0;
            state_d = ST_IDLE;
          end
          EV_COMMIT: begin
            if (state_q == ST_ENTRY && count_q == 3'(DIGITS)) state_d = ST_QTY;
            else                                             err_d   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_QTY: begin
        case (ev)
          EV_DIGIT: begin
            qty_d   = ev_digit;
            state_d = ST_OUT;
          end
          EV_BACK:   state_d = ST_ENTRY;
          EV_CLEAR: begin
            code_d  = '0;
            count_d = '0;
            qty_d   = '0;
            state_d = ST_IDLE;
          end
          EV_COMMIT: err_d = 1'b1;
          default: ;
        endcase
      end
      ST_OUT: begin
        // Record is frozen until downstream takes it; keys are ignored here.
        if (item_ready_i) begin
          code_d  = '0;
          count_d = '0;
          qty_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Shift synchronizer and FSM/datapath registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      shift1_q <= 1'b0;
      shift2_q <= 1'b0;
      state_q  <= ST_IDLE;
      code_q   <= '0;
      count_q  <= '0;
      qty_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      shift1_q <= SW_SHIFT;
      shift2_q <= shift1_q;
      state_q  <= state_d;
      code_q   <= code_d;
      count_q  <= count_d;
      qty_q    <= qty_d;
      err_q    <= err_d;
    end
  end

  assign code_o       = code_q;
  assign count_o      = count_q;
  assign qty_o        = qty_q;
  assign err_o        = err_q;
  assign state_o      = state_q;
  assign item_valid_o = (state_q == ST_OUT);

endmodule

// File: tb/tb_barcode_entry.sv
// Bench for barcode_entry: directed scenarios plus random key sequences,
// item records checked through a scoreboard queue against a behavioural model.
module tb_barcode_entry;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [3:0]  KEY      = 4'hF;
  logic        SW_SHIFT = 1'b0;
  logic        item_ready_i = 1'b0;
  logic [15:0] code_o;
  logic [2:0]  count_o, qty_o;
  logic        item_valid_o, err_o;
  logic [1:0]  state_o;

  always #5 CLOCK_50 = ~CLOCK_50;

  barcode_entry #(.DEBOUNCE_CYCLES(4), .DIGITS(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .KEY          (KEY),
    .SW_SHIFT     (SW_SHIFT),
    .code_o       (code_o),
    .count_o      (count_o),
    .qty_o        (qty_o),
    .item_valid_o (item_valid_o),
    .item_ready_i (item_ready_i),
    .err_o        (err_o),
    .state_o      (state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int code; int qty;} rec_t;
  int   m_digits[$];       // entered digits, oldest first
  int   m_phase = 0;       // 0 entering digits, 1 waiting for qty, 2 record pending
  int   m_qty   = 0;
  int   exp_err = 0;
  rec_t exp_q[$];

  function automatic int m_code();
    int c = 0;
    foreach (m_digits[i]) c = c * 16 + m_digits[i];
    return c;
  endfunction

  function automatic int m_state();
    if (m_phase == 1) return 2;
    if (m_phase == 2) return 3;
    return (m_digits.size() == 0) ? 0 : 1;
  endfunction

  function automatic void m_clear();
    m_digits.delete();
    m_qty   = 0;
    m_phase = 0;
  endfunction

  function automatic void m_event(input logic [3:0] mask, input bit shift);
    int idx = -1;
    for (int i = 0; i < 4; i++) if (mask[i]) idx = i;
    if (idx < 0 || m_phase == 2) return;
    if (!shift) begin
      int d;
      d = 4 - idx;
      if (m_phase == 1) begin
        m_qty   = d;
        m_phase = 2;
        exp_q.push_back('{m_code(), d});
      end else if (m_digits.size() == 4) exp_err++;
      else m_digits.push_back(d);
    end else begin
      case (idx)
        3: if (m_phase == 0 && m_digits.size() == 4) m_phase = 1; else exp_err++;
        2: begin
          if (m_phase == 1) m_phase = 0;
          else if (m_digits.size() > 0) m_digits.delete(m_digits.size() - 1);
        end
        1: m_clear();
        default: ;
      endcase
    end
  endfunction

  // ---------------- ready driver ----------------
  int rdy_mode = 0;   // 0 manual, 1 random, 2 always high
  initial forever begin
    @(posedge CLOCK_50);
    #1;
    if (rdy_mode == 1)      item_ready_i = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) item_ready_i = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int err_seen = 0;
  int err_run  = 0;
  initial forever begin
    @(negedge CLOCK_50);
    if (RESET_N && item_valid_o && item_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL item_unexpected: got code %h qty %0d, required no record", code_o, qty_o);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        check("item_code", 32'(code_o), 32'(r.code));
        check("item_qty", 32'(qty_o), 32'(r.qty));
        m_clear();
      end
    end
    if (err_o) begin
      if (err_run == 0) err_seen++;
      err_run++;
    end else if (err_run != 0) begin
      check("err_width", 32'(err_run), 32'd1);
      err_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [3:0] mask, input bit shift);
    SW_SHIFT = shift;
    repeat (3) tick();
    m_event(mask, shift);
    KEY = KEY & ~mask;
    repeat (10) tick();
    KEY = KEY | mask;
    repeat (10) tick();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"},  32'(code_o),       32'(m_code()));
    check({tag, "_count"}, 32'(count_o),      32'(m_digits.size()));
    check({tag, "_state"}, 32'(state_o),      32'(m_state()));
    check({tag, "_qty"},   32'(qty_o),        32'(m_qty));
    check({tag, "_valid"}, 32'(item_valid_o), 32'(m_phase == 2));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_code"},  32'(code_o),       32'd0);
    check({tag, "_count"}, 32'(count_o),      32'd0);
    check({tag, "_qty"},   32'(qty_o),        32'd0);
    check({tag, "_valid"}, 32'(item_valid_o), 32'd0);
    check({tag, "_err"},   32'(err_o),        32'd0);
    check({tag, "_state"}, 32'(state_o),      32'd0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge CLOCK_50);
    #3;
    RESET_N = 1'b0;
    #1;
    reset_checks(tag);
    m_clear();
    exp_q.delete();
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (5) tick();
  endtask

  task automatic wait_not_out();
    for (int i = 0; i < 200 && m_phase == 2; i++) tick();
    if (m_phase == 2) check("handshake_timeout", 32'(item_valid_o), 32'd0);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a, 0); press(b, 0); press(c, 0); press(d, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0;
    logic [3:0] mask;
    bit shift;

    repeat (3) tick();
    reset_checks("por");
    RESET_N = 1'b1;
    repeat (5) tick();

    // 1: full item, one-cycle ready pulse
    enter4(4'b1000, 4'b0100, 4'b1000, 4'b0010);
    press(4'b1000, 1);
    check("t1_code_const", 32'(code_o), 32'h1213);
    check_outputs("t1_qty");
    press(4'b0010, 0);
    check("t1_qty_const", 32'(qty_o), 32'd3);
    check_outputs("t1_out");
    item_ready_i = 1'b1;
    tick();
    item_ready_i = 1'b0;
    check_outputs("t1_done");

    // 2: short press and bouncing give no event
    KEY[2] = 1'b0;
    repeat (3) tick();
    KEY[2] = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 20; i++) begin
      KEY[2] = ~KEY[2];
      tick();
    end
    KEY[2] = 1'b1;
    repeat (10) tick();
    check_outputs("t2_bounce");

    // 3: early commit rejected
    e0 = err_seen;
    press(4'b1000, 0); press(4'b0100, 0); press(4'b1000, 1);
    check("t3_err_pulses", 32'(err_seen - e0), 32'd1);
    check("t3_code_const", 32'(code_o), 32'h0012);
    check_outputs("t3");
    press(4'b0010, 1);

    // 4: backspace, clear, overflow digit
    press(4'b1000, 0); press(4'b0100, 0); press(4'b0010, 0);
    press(4'b0100, 1);
    check_outputs("t4_back");
    press(4'b0010, 1);
    check_outputs("t4_clear");
    enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    e0 = err_seen;
    press(4'b0001, 0);
    check("t4_overflow_err", 32'(err_seen - e0), 32'd1);
    check_outputs("t4_overflow");

    // 5: record held while downstream stalls; keys ignored
    press(4'b1000, 1);
    press(4'b0100, 0);
    check_outputs("t5_out");
    e0 = err_seen;
    press(4'b1000, 0); press(4'b1000, 1); press(4'b0100, 1); press(4'b0010, 1);
    check("t5_no_err", 32'(err_seen - e0), 32'd0);
    check_outputs("t5_held");
    item_ready_i = 1'b1;
    tick();
    item_ready_i = 1'b0;
    check_outputs("t5_done");
    press(4'b1000, 0);
    press(4'b1010, 0);
    check_outputs("t5_simul");
    press(4'b0010, 1);

    // 6: reset in QTY, in OUT, and with a key held through reset
    enter4(4'b1000, 4'b1000, 4'b0100, 4'b0100);
    press(4'b1000, 1);
    async_reset("t6_rst_qty");
    enter4(4'b0001, 4'b0001, 4'b0010, 4'b0100);
    press(4'b1000, 1);
    press(4'b0001, 0);
    async_reset("t6_rst_out");
    KEY[3] = 1'b0;
    repeat (5) tick();
    RESET_N = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (30) tick();
    check_outputs("t6_held");
    KEY[3] = 1'b1;
    repeat (10) tick();
    press(4'b1000, 0);
    check_outputs("t6_repress");
    press(4'b0010, 1);

    // random key sequences with a randomly stalling downstream
    rdy_mode = 1;
    for (int n = 0; n < 80; n++) begin
      wait_not_out();
      mask = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) mask = mask | 4'(1 << $urandom_range(0, 3));
      shift = ($urandom_range(0, 9) < 3);
      press(mask, shift);
      check_outputs("rnd");
    end

    rdy_mode = 2;
    wait_not_out();
    repeat (5) tick();
    check("err_total", 32'(err_seen), 32'(exp_err));
    check("items_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
